pc_unit: RTL and testbench

PC_UNIT -- requirements
Module: pc_unit

---
 rtl/pc_unit.sv | 125 ++++++++++++
 tb/tb_pc_unit.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// Program counter unit: next-PC selection (trap/mret/redirect/stall/RAS/sequential)
// Latency: one cycle from any accepted next-PC source to pc; pc_seq is combinational
// Stall holds pc and RAS; trap, mret and redirect override stall. Optional RAS: PC_UNIT_RAS_EN
module pc_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              C_EXT        = 0,
    parameter int              RAS_DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            inst_len16,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_vector,
    input  logic            mret_valid,
    input  logic [XLEN-1:0] mepc,
    input  logic            ras_push,
    input  logic            ras_pop,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_seq,
    output logic            misalign_err,
    output logic [XLEN-1:0] bad_addr,
    output logic            ras_empty
);

    logic [XLEN-1:0] r_pc;
    logic            r_misalign_err;
    logic [XLEN-1:0] r_bad_addr;

    logic [XLEN-1:0] w_step;
    logic [XLEN-1:0] w_pc_seq;
    logic [XLEN-1:0] w_trap_pc;
    logic [XLEN-1:0] w_mret_pc;
    logic            w_tgt_misaligned;
    logic            w_seq_ok;
    logic            w_pop_hit;
    logic [XLEN-1:0] w_ras_top;

    assign w_step           = ((C_EXT != 0) && inst_len16) ? XLEN'(2) : XLEN'(4);
    assign w_pc_seq         = r_pc + w_step;
    assign w_trap_pc        = {trap_vector[XLEN-1:2], 2'b00};
    assign w_mret_pc        = (C_EXT != 0) ? {mepc[XLEN-1:1], 1'b0} : {mepc[XLEN-1:2], 2'b00};
    assign w_tgt_misaligned = redirect_target[0] | ((C_EXT == 0) & redirect_target[1]);
    // Only a plain, unstalled cycle may touch the return-address stack
    assign w_seq_ok         = ~trap_valid & ~mret_valid & ~redirect_valid & ~stall;

`ifdef PC_UNIT_RAS_EN
    localparam int PTR_W = $clog2(RAS_DEPTH);

    // Circular buffer: r_top indexes the newest entry; a push on a full stack
    // lands on the oldest slot, so the count saturates at RAS_DEPTH.
    logic [XLEN-1:0]  r_ras [RAS_DEPTH];
    logic [PTR_W-1:0] r_top;
    logic [PTR_W:0]   r_cnt;
    logic             w_push_do;
    logic [PTR_W-1:0] w_top_inc;

    assign w_push_do = w_seq_ok & ras_push;
    assign w_pop_hit = w_seq_ok & ras_pop & (r_cnt != '0);
    assign w_ras_top = r_ras[r_top];
    assign w_top_inc = r_top + PTR_W'(1);
    assign ras_empty = (r_cnt == '0);

    // Stack update: combined push+pop replaces the top in place
    always_ff @(posedge clk) begin
        if (rst) begin
            r_top <= '0;
            r_cnt <= '0;
        end else if (w_push_do && w_pop_hit) begin
            r_ras[r_top] <= w_pc_seq;
        end else if (w_pop_hit) begin
            r_top <= r_top - PTR_W'(1);
            r_cnt <= r_cnt - (PTR_W+1)'(1);
        end else if (w_push_do) begin
            r_top            <= w_top_inc;
            r_ras[w_top_inc] <= w_pc_seq;
            if (r_cnt != (PTR_W+1)'(RAS_DEPTH)) begin
                r_cnt <= r_cnt + (PTR_W+1)'(1);
            end
        end
    end
`else
    logic w_unused_ras;

    assign w_unused_ras = ras_push ^ ras_pop;
    assign w_pop_hit    = 1'b0;
    assign w_ras_top    = '0;
    assign ras_empty    = 1'b1;
`endif

    // Next-PC selection in priority order; misalign flag lives for one cycle only
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc           <= RESET_VECTOR;
            r_misalign_err <= 1'b0;
            r_bad_addr     <= '0;
        end else begin
            r_misalign_err <= 1'b0;
            r_bad_addr     <= '0;
            if (trap_valid) begin
                r_pc <= w_trap_pc;
            end else if (mret_valid) begin
                r_pc <= w_mret_pc;
            end else if (redirect_valid) begin
                if (w_tgt_misaligned) begin
                    r_misalign_err <= 1'b1;
                    r_bad_addr     <= redirect_target;
                end else begin
                    r_pc <= redirect_target;
                end
            end else if (!stall) begin
                r_pc <= w_pop_hit ? w_ras_top : w_pc_seq;
            end
        end
    end

    assign pc           = r_pc;
    assign pc_seq       = w_pc_seq;
    assign misalign_err = r_misalign_err;
    assign bad_addr     = r_bad_addr;

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: two instances (C_EXT=0 and C_EXT=1) share one stimulus stream
// Each is checked every cycle against a behavioural model, plus literal spot checks
// RAS expectations follow PC_UNIT_RAS_EN as seen by this compile
module tb_pc_unit;

    localparam logic [31:0] RV = 32'h100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0, inst_len16 = 1'b0;
    logic        redirect_valid = 1'b0, trap_valid = 1'b0, mret_valid = 1'b0;
    logic [31:0] redirect_target = '0, trap_vector = '0, mepc = '0;
    logic        ras_push = 1'b0, ras_pop = 1'b0;

    logic [31:0] d_pc [2];
    logic [31:0] d_seq [2];
    logic [31:0] d_bad [2];
    logic        d_err [2];
    logic        d_emp [2];

    int n_chk = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    // Model state: stack entry 0 is the most recent push
    logic [31:0] m_pc [2];
    logic [31:0] m_bad [2];
    logic        m_err [2];
    int          m_cnt [2];
    logic [31:0] m_stk [2][4];

    logic [31:0] n_pc [2];
    logic [31:0] n_bad [2];
    logic        n_err [2];
    int          n_cnt [2];
    logic [31:0] n_stk [2][4];

    always #5 clk = ~clk;

    pc_unit #(.XLEN(32), .RESET_VECTOR(RV), .C_EXT(0), .RAS_DEPTH(4)) u0 (
        .clk(clk), .rst(rst), .stall(stall), .inst_len16(inst_len16),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .trap_valid(trap_valid), .trap_vector(trap_vector),
        .mret_valid(mret_valid), .mepc(mepc),
        .ras_push(ras_push), .ras_pop(ras_pop),
        .pc(d_pc[0]), .pc_seq(d_seq[0]), .misalign_err(d_err[0]),
        .bad_addr(d_bad[0]), .ras_empty(d_emp[0])
    );

    pc_unit #(.XLEN(32), .RESET_VECTOR(RV), .C_EXT(1), .RAS_DEPTH(4)) u1 (
        .clk(clk), .rst(rst), .stall(stall), .inst_len16(inst_len16),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .trap_valid(trap_valid), .trap_vector(trap_vector),
        .mret_valid(mret_valid), .mepc(mepc),
        .ras_push(ras_push), .ras_pop(ras_pop),
        .pc(d_pc[1]), .pc_seq(d_seq[1]), .misalign_err(d_err[1]),
        .bad_addr(d_bad[1]), .ras_empty(d_emp[1])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    endtask

    function automatic logic [31:0] step_of(input int k);
        return (k == 1 && inst_len16) ? 32'd2 : 32'd4;
    endfunction

    // Architectural rules applied to the current inputs and model state
    task automatic model_next(input int k);
        logic [31:0] seq;
        seq = m_pc[k] + step_of(k);
        n_pc[k]  = m_pc[k];
        n_cnt[k] = m_cnt[k];
        for (int j = 0; j < 4; j++) n_stk[k][j] = m_stk[k][j];
        n_err[k] = 1'b0;
        n_bad[k] = '0;
        if (rst) begin
            n_pc[k]  = RV;
            n_cnt[k] = 0;
        end else if (trap_valid) begin
            n_pc[k] = trap_vector & ~32'h3;
        end else if (mret_valid) begin
            n_pc[k] = (k == 1) ? (mepc & ~32'h1) : (mepc & ~32'h3);
        end else if (redirect_valid) begin
            if (redirect_target[0] || (k == 0 && redirect_target[1])) begin
                n_err[k] = 1'b1;
                n_bad[k] = redirect_target;
            end else begin
                n_pc[k] = redirect_target;
            end
        end else if (!stall) begin
            n_pc[k] = seq;
`ifdef PC_UNIT_RAS_EN
            if (ras_pop && n_cnt[k] > 0) begin
                n_pc[k] = n_stk[k][0];
                for (int j = 0; j < 3; j++) n_stk[k][j] = n_stk[k][j+1];
                n_cnt[k]--;
            end
            if (ras_push) begin
                for (int j = 3; j > 0; j--) n_stk[k][j] = n_stk[k][j-1];
                n_stk[k][0] = seq;
                if (n_cnt[k] < 4) n_cnt[k]++;
            end
`endif
        end
    endtask

    task automatic tick();
        model_next(0);
        model_next(1);
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            m_pc[k]  = n_pc[k];
            m_bad[k] = n_bad[k];
            m_err[k] = n_err[k];
            m_cnt[k] = n_cnt[k];
            for (int j = 0; j < 4; j++) m_stk[k][j] = n_stk[k][j];
        end
        #1;
    endtask

    task automatic clear_in();
        stall = 0; inst_len16 = 0; redirect_valid = 0; trap_valid = 0;
        mret_valid = 0; ras_push = 0; ras_pop = 0;
    endtask

    // Per-cycle comparison against the model, away from the rising edge
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("pc[u%0d]", k), d_pc[k], m_pc[k]);
                chk($sformatf("pc_seq[u%0d]", k), d_seq[k], m_pc[k] + step_of(k));
                chk($sformatf("misalign_err[u%0d]", k), {31'b0, d_err[k]}, {31'b0, m_err[k]});
                chk($sformatf("bad_addr[u%0d]", k), d_bad[k], m_bad[k]);
                chk($sformatf("ras_empty[u%0d]", k), {31'b0, d_emp[k]}, {31'b0, (m_cnt[k] == 0)});
            end
        end
    end

    typedef struct packed {
        logic stall; logic push; logic pop; logic len16; logic trap;
    } vec_t;

    vec_t mix [12];

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_pc[k] = '0; m_bad[k] = '0; m_err[k] = 0; m_cnt[k] = 0;
            for (int j = 0; j < 4; j++) m_stk[k][j] = '0;
        end
        #2;
        // Reset with noisy inputs asserted
        rst = 1; stall = 1; redirect_valid = 1; redirect_target = 32'h300;
        tick();
        chk_en = 1;
        tick();
        chk("rst_pc", d_pc[0], 32'h100);
        chk("rst_err", {31'b0, d_err[0]}, 32'h0);
        chk("rst_bad", d_bad[0], 32'h0);
        chk("rst_empty", {31'b0, d_emp[0]}, 32'h1);
        clear_in();
        rst = 0;
        chk("first_fetch", d_pc[0], 32'h100);
        tick(); chk("seq1", d_pc[0], 32'h104);
        tick(); chk("seq2", d_pc[0], 32'h108);
        tick(); chk("seq3", d_pc[0], 32'h10C);

        // Redirect beats stall, then stall holds
        redirect_valid = 1; redirect_target = 32'h200; tick();
        chk("redir_200", d_pc[0], 32'h200);
        stall = 1; redirect_target = 32'h400; tick();
        chk("redir_over_stall", d_pc[0], 32'h400);
        redirect_valid = 0; tick();
        chk("stall_hold", d_pc[0], 32'h400);
        stall = 0;

        // Half-word target: misaligned without C, legal with C
        redirect_valid = 1; redirect_target = 32'h402; tick();
        chk("mis_hold_c0", d_pc[0], 32'h400);
        chk("mis_err_c0", {31'b0, d_err[0]}, 32'h1);
        chk("mis_bad_c0", d_bad[0], 32'h402);
        chk("c1_redir_402", d_pc[1], 32'h402);
        chk("c1_no_err", {31'b0, d_err[1]}, 32'h0);
        redirect_valid = 0; tick();
        chk("mis_err_clears", {31'b0, d_err[0]}, 32'h0);
        chk("c1_seq_406", d_pc[1], 32'h406);
        inst_len16 = 1; #1;
        chk("c1_seq16", d_seq[1], 32'h408);
        chk("c0_ignores_len16", d_seq[0], 32'h408);
        tick(); inst_len16 = 0;
        redirect_valid = 1; redirect_target = 32'h401; tick();
        chk("c1_odd_err", {31'b0, d_err[1]}, 32'h1);
        chk("c1_odd_hold", d_pc[1], 32'h408);
        redirect_valid = 0;

        // Trap beats redirect and stall; then mret
        trap_valid = 1; trap_vector = 32'h803; redirect_valid = 1;
        redirect_target = 32'h1000; stall = 1; tick();
        chk("trap_pc", d_pc[0], 32'h800);
        chk("trap_pc_c1", d_pc[1], 32'h800);
        clear_in();
        mret_valid = 1; mepc = 32'h1234; tick();
        chk("mret_pc", d_pc[0], 32'h1234);
        mepc = 32'h1237; tick();
        chk("mret_mask_c0", d_pc[0], 32'h1234);
        chk("mret_mask_c1", d_pc[1], 32'h1236);
        clear_in();

        // Wrap past the top of the address space
        redirect_valid = 1; redirect_target = 32'hFFFF_FFFC; tick();
        redirect_valid = 0; tick();
        chk("wrap_pc", d_pc[0], 32'h0);
        chk("wrap_err", {31'b0, d_err[0]}, 32'h0);

        // Five calls into a four-deep stack, then five returns
        for (int i = 1; i <= 5; i++) begin
            redirect_valid = 1; redirect_target = 32'h10 * i; tick();
            redirect_valid = 0; ras_push = 1; tick();
            ras_push = 0;
        end
        ras_pop = 1;
`ifdef PC_UNIT_RAS_EN
        tick(); chk("pop1", d_pc[0], 32'h54);
        tick(); chk("pop2", d_pc[0], 32'h44);
        tick(); chk("pop3", d_pc[0], 32'h34);
        tick(); chk("pop4", d_pc[0], 32'h24);
        chk("pop4_empty", {31'b0, d_emp[0]}, 32'h1);
        tick(); chk("pop5_seq", d_pc[0], 32'h28);
`else
        tick(); chk("nopop1", d_pc[0], 32'h58);
        tick(); chk("nopop2", d_pc[0], 32'h5C);
        tick(); chk("nopop3", d_pc[0], 32'h60);
        tick(); chk("nopop4", d_pc[0], 32'h64);
        chk("nopop_empty", {31'b0, d_emp[0]}, 32'h1);
        tick(); chk("nopop5", d_pc[0], 32'h68);
`endif
        ras_pop = 0;

        // Mixed push/pop/stall/trap cycles, checked by the model
        mix[0]  = '{stall:0, push:1, pop:0, len16:0, trap:0};
        mix[1]  = '{stall:0, push:1, pop:0, len16:1, trap:0};
        mix[2]  = '{stall:0, push:1, pop:1, len16:0, trap:0};
        mix[3]  = '{stall:1, push:1, pop:1, len16:0, trap:0};
        mix[4]  = '{stall:0, push:1, pop:0, len16:0, trap:1};
        mix[5]  = '{stall:0, push:0, pop:1, len16:1, trap:0};
        mix[6]  = '{stall:1, push:0, pop:1, len16:0, trap:0};
        mix[7]  = '{stall:0, push:1, pop:0, len16:0, trap:0};
        mix[8]  = '{stall:0, push:1, pop:0, len16:0, trap:0};
        mix[9]  = '{stall:0, push:1, pop:0, len16:1, trap:0};
        mix[10] = '{stall:0, push:1, pop:1, len16:0, trap:0};
        mix[11] = '{stall:0, push:0, pop:1, len16:0, trap:0};
        trap_vector = 32'h2000;
        for (int i = 0; i < 12; i++) begin
            stall = mix[i].stall; ras_push = mix[i].push; ras_pop = mix[i].pop;
            inst_len16 = mix[i].len16; trap_valid = mix[i].trap;
            tick();
        end
        for (int i = 0; i < 6; i++) begin
            ras_pop = 1; tick();
        end
        clear_in();

        // Reset in the middle of a stalled redirect
        stall = 1; redirect_valid = 1; redirect_target = 32'h300; rst = 1; tick();
        chk("rst_mid_pc", d_pc[0], 32'h100);
        chk("rst_mid_empty", {31'b0, d_emp[0]}, 32'h1);
        clear_in(); rst = 0;
        tick(); chk("post_rst_seq", d_pc[0], 32'h104);
        tick();
        @(negedge clk); #1;
        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
